pal_syncgen: RTL and testbench

Raster timing generator for the 7 MHz PAL-style video chain. It produces the horizontal and vertical counters (`hc`, `vc`) that drive the frame generator, plus composite sync, blanking and frame-tick signals. The sync and blank outputs lag the counters by one clock, so they stay aligned with the frame generator's one-cycle-registered `video_out` at the composite mixer. The frame is 312 progressive lines of 448 clocks (64 µs at 7 MHz), with an active area of 390x304.

---
 rtl/pal_syncgen_if.sv | 11 +
 rtl/pal_syncgen.sv | 88 ++++++++
 tb/tb_pal_syncgen.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pal_syncgen_if.sv
// rtl/pal_syncgen_if.sv - raster position and sync bundle from the PAL timing generator
interface pal_syncgen_if;
   logic [8:0] hc;
   logic [8:0] vc;
   logic       blank;
   logic       csync_n;
   logic       frame_tick;

   modport master (output hc, vc, blank, csync_n, frame_tick);
   modport slave  (input  hc, vc, blank, csync_n, frame_tick);
endinterface

// File: rtl/pal_syncgen.sv
// rtl/pal_syncgen.sv - PAL raster counters with composite sync, blank and frame tick
// Sync/blank/tick are registered decodes of the previous hc/vc, matching the frame generator's one-cycle video path.
module pal_syncgen #(
   parameter int HTOTAL      = 448,
   parameter int HACTIVE     = 390,
   parameter int HSYNC_START = 400,
   parameter int HSYNC_LEN   = 33,
   parameter int EQ_LEN      = 16,
   parameter int BROAD_LEN   = 191,
   parameter int VTOTAL      = 312,
   parameter int VACTIVE     = 304
) (
   input  logic          clk7,
   input  logic          rst_n,
   pal_syncgen_if.master sg
);
   localparam int HALF = HTOTAL / 2;

   localparam logic [8:0] H_LAST  = 9'(HTOTAL - 1);
   localparam logic [8:0] V_LAST  = 9'(VTOTAL - 1);
   localparam logic [8:0] V_EQ1   = 9'(VACTIVE);
   localparam logic [8:0] V_BROAD = 9'(VACTIVE + 2);
   localparam logic [8:0] V_EQ2   = 9'(VACTIVE + 4);
   localparam logic [8:0] V_NORM  = 9'(VACTIVE + 6);

   logic [8:0] hc_q, hc_d;
   logic [8:0] vc_q, vc_d;
   logic       blank_q, blank_d;
   logic       csync_n_q, csync_n_d;
   logic       frame_tick_q, frame_tick_d;

   logic [8:0] sl;
   logic [8:0] p;
   logic [7:0] q;
   logic       sync_low;

   always_comb begin
      hc_d = (hc_q == H_LAST) ? '0 : hc_q + 9'd1;
      vc_d = vc_q;
      if (hc_q == H_LAST) begin
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + 9'd1;
      end

      // Sync lines start at HSYNC_START, so the part of a line before it belongs to the previous sync line.
      if (hc_q >= 9'(HSYNC_START)) begin
         sl = vc_q;
         p  = hc_q - 9'(HSYNC_START);
      end else begin
         sl = (vc_q == '0) ? V_LAST : vc_q - 9'd1;
         p  = hc_q + 9'(HTOTAL - HSYNC_START);
      end
      q = (p >= 9'(HALF)) ? 8'(p - 9'(HALF)) : p[7:0];

      if ((sl >= V_EQ1 && sl < V_BROAD) || (sl >= V_EQ2 && sl < V_NORM)) begin
         sync_low = (q < 8'(EQ_LEN));
      end else if (sl >= V_BROAD && sl < V_EQ2) begin
         sync_low = (q < 8'(BROAD_LEN));
      end else begin
         sync_low = (p < 9'(HSYNC_LEN));
      end

      blank_d      = !((hc_q < 9'(HACTIVE)) && (vc_q < 9'(VACTIVE)));
      csync_n_d    = !sync_low;
      frame_tick_d = (hc_q == '0) && (vc_q == '0);
   end

   always_ff @(posedge clk7 or negedge rst_n) begin
      if (!rst_n) begin
         hc_q         <= '0;
         vc_q         <= '0;
         blank_q      <= 1'b1;
         csync_n_q    <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         hc_q         <= hc_d;
         vc_q         <= vc_d;
         blank_q      <= blank_d;
         csync_n_q    <= csync_n_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign sg.hc         = hc_q;
   assign sg.vc         = vc_q;
   assign sg.blank      = blank_q;
   assign sg.csync_n    = csync_n_q;
   assign sg.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_pal_syncgen.sv
// tb/tb_pal_syncgen.sv - self-checking bench for pal_syncgen against a position-based raster model
// Vertical size is shrunk (same offsets from VACTIVE) so whole frames fit a short run.
module tb_pal_syncgen;
   localparam int HT    = 448;
   localparam int HA    = 390;
   localparam int HSS   = 400;
   localparam int HSL   = 33;
   localparam int EQ    = 16;
   localparam int BROAD = 191;
   localparam int VT    = 16;
   localparam int VA    = 8;
   localparam int HALF  = HT / 2;

   logic clk7;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   int   mh;
   int   mv;
   logic [2:0] mo;

   pal_syncgen_if sg ();

   pal_syncgen #(
      .HTOTAL(HT), .HACTIVE(HA), .HSYNC_START(HSS), .HSYNC_LEN(HSL),
      .EQ_LEN(EQ), .BROAD_LEN(BROAD), .VTOTAL(VT), .VACTIVE(VA)
   ) dut (
      .clk7  (clk7),
      .rst_n (rst_n),
      .sg    (sg)
   );

   initial clk7 = 1'b0;
   always #5 clk7 = ~clk7;

   // {blank, csync_n, frame_tick} for raster position (h,v), straight from the line-type rules.
   function automatic logic [2:0] ref_out(int h, int v);
      int sl, p, q;
      logic low;
      if (h >= HSS) begin
         sl = v;
         p  = h - HSS;
      end else begin
         sl = (v + VT - 1) % VT;
         p  = h + HT - HSS;
      end
      q = p % HALF;
      if ((sl >= VA && sl < VA + 2) || (sl >= VA + 4 && sl < VA + 6)) low = (q < EQ);
      else if (sl >= VA + 2 && sl < VA + 4) low = (q < BROAD);
      else low = (p < HSL);
      return {!(h < HA && v < VA), !low, (h == 0 && v == 0)};
   endfunction

   function automatic logic [20:0] obs();
      return {sg.hc, sg.vc, sg.blank, sg.csync_n, sg.frame_tick};
   endfunction

   function automatic logic [20:0] expv();
      return {9'(mh), 9'(mv), mo};
   endfunction

   function automatic string fmt(logic [20:0] x);
      return $sformatf("hc=%0d vc=%0d blank=%b csync_n=%b tick=%b", x[20:12], x[11:3], x[2], x[1], x[0]);
   endfunction

   task automatic step();
      @(posedge clk7);
      if (rst_n) begin
         mo = ref_out(mh, mv);
         mh = mh + 1;
         if (mh == HT) begin
            mh = 0;
            mv = (mv + 1) % VT;
         end
      end else begin
         mh = 0;
         mv = 0;
         mo = 3'b110;
      end
      @(negedge clk7);
   endtask

   task automatic run_until(int h, int v);
      for (int i = 0; i <= HT * VT && !(mh == h && mv == v); i++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_assert++;
         if (obs() !== {9'd0, 9'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL reset_hold got %s want hc=0 vc=0 blank=1 csync_n=1 tick=0", fmt(obs()));
         end
      end
      rst_n = 1'b1;
      step();
      n_assert++;
      if (obs() !== {9'd1, 9'd0, 3'b011}) begin
         n_fail++;
         $display("FAIL reset_release got %s want hc=1 vc=0 blank=0 csync_n=1 tick=1", fmt(obs()));
      end
   endtask

   task automatic test_normal_line();
      int n;
      run_until(390, 1);
      n_assert++;
      if (sg.blank !== 1'b0) begin
         n_fail++;
         $display("FAIL blank_last_active got %b want 0", sg.blank);
      end
      step();
      n_assert++;
      if (sg.blank !== 1'b1) begin
         n_fail++;
         $display("FAIL blank_first_inactive got %b want 1", sg.blank);
      end
      run_until(400, 1);
      n_assert++;
      if (sg.csync_n !== 1'b1) begin
         n_fail++;
         $display("FAIL hsync_before got %b want 1", sg.csync_n);
      end
      step();
      n_assert++;
      if (sg.csync_n !== 1'b0) begin
         n_fail++;
         $display("FAIL hsync_start got %b want 0", sg.csync_n);
      end
      run_until(433, 1);
      n_assert++;
      if (sg.csync_n !== 1'b0) begin
         n_fail++;
         $display("FAIL hsync_last got %b want 0", sg.csync_n);
      end
      step();
      n_assert++;
      if (sg.csync_n !== 1'b1) begin
         n_fail++;
         $display("FAIL hsync_end got %b want 1", sg.csync_n);
      end
      n = $urandom_range(900, 2400);
      for (int i = 0; i < n; i++) begin
         step();
         n_assert++;
         if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL normal_run got %s want %s", fmt(obs()), fmt(expv()));
         end
      end
   endtask

   task automatic test_vertical_interval();
      int n33, n16, n191, nbad, run, low_total, ticks;
      n33 = 0; n16 = 0; n191 = 0; nbad = 0; run = 0; low_total = 0; ticks = 0;
      run_until(1, 0);
      for (int i = 0; i < HT * VT; i++) begin
         n_assert++;
         if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL frame_run got %s want %s", fmt(obs()), fmt(expv()));
         end
         if (sg.frame_tick === 1'b1) ticks++;
         if (sg.csync_n === 1'b0) begin
            run++;
            low_total++;
         end else if (run > 0) begin
            if (run == HSL) n33++;
            else if (run == EQ) n16++;
            else if (run == BROAD) n191++;
            else nbad++;
            run = 0;
         end
         step();
      end
      n_assert++;
      if (sg.frame_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_period tick got %b want 1", sg.frame_tick);
      end
      n_assert++;
      if (n33 != VT - 6) begin
         n_fail++;
         $display("FAIL runs_33 got %0d want %0d", n33, VT - 6);
      end
      n_assert++;
      if (n16 != 8) begin
         n_fail++;
         $display("FAIL runs_16 got %0d want 8", n16);
      end
      n_assert++;
      if (n191 != 4) begin
         n_fail++;
         $display("FAIL runs_191 got %0d want 4", n191);
      end
      n_assert++;
      if (nbad != 0) begin
         n_fail++;
         $display("FAIL runs_other got %0d want 0", nbad);
      end
      n_assert++;
      if (low_total != (VT - 6) * HSL + 8 * EQ + 4 * BROAD) begin
         n_fail++;
         $display("FAIL low_total got %0d want %0d", low_total, (VT - 6) * HSL + 8 * EQ + 4 * BROAD);
      end
      n_assert++;
      if (ticks != 1) begin
         n_fail++;
         $display("FAIL ticks_per_frame got %0d want 1", ticks);
      end
   endtask

   task automatic test_broad_wrap();
      int lows;
      lows = 0;
      run_until(400, VA + 2);
      n_assert++;
      if (sg.csync_n !== 1'b1) begin
         n_fail++;
         $display("FAIL broad_before got %b want 1", sg.csync_n);
      end
      step();
      for (int i = 0; i < HT && !(mh == 144 && mv == VA + 3); i++) begin
         if (sg.csync_n === 1'b0) lows++;
         step();
      end
      n_assert++;
      if (lows != BROAD) begin
         n_fail++;
         $display("FAIL broad_width got %0d want %0d", lows, BROAD);
      end
      n_assert++;
      if (obs() !== {9'd144, 9'(VA + 3), 3'b110}) begin
         n_fail++;
         $display("FAIL broad_end got %s want hc=144 vc=%0d blank=1 csync_n=1 tick=0", fmt(obs()), VA + 3);
      end
   endtask

   task automatic test_async_reset(int h, int v, string tag);
      run_until(h, v);
      n_assert++;
      if (obs() !== expv()) begin
         n_fail++;
         $display("FAIL %s_pre got %s want %s", tag, fmt(obs()), fmt(expv()));
      end
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      n_assert++;
      if (obs() !== {9'd0, 9'd0, 3'b110}) begin
         n_fail++;
         $display("FAIL %s_immediate got %s want hc=0 vc=0 blank=1 csync_n=1 tick=0", tag, fmt(obs()));
      end
      mh = 0;
      mv = 0;
      mo = 3'b110;
      @(negedge clk7);
      repeat ($urandom_range(1, 4)) step();
      rst_n = 1'b1;
      step();
      n_assert++;
      if (obs() !== {9'd1, 9'd0, 3'b011} || expv() !== {9'd1, 9'd0, 3'b011}) begin
         n_fail++;
         $display("FAIL %s_restart got %s want hc=1 vc=0 blank=0 csync_n=1 tick=1", tag, fmt(obs()));
      end
   endtask

   task automatic test_frame_wrap();
      run_until(447, VT - 1);
      n_assert++;
      if (sg.blank !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_pre blank got %b want 1", sg.blank);
      end
      step();
      n_assert++;
      if (obs() !== {9'd0, 9'd0, 3'b110}) begin
         n_fail++;
         $display("FAIL wrap_edge got %s want hc=0 vc=0 blank=1 csync_n=1 tick=0", fmt(obs()));
      end
      step();
      n_assert++;
      if (obs() !== {9'd1, 9'd0, 3'b011}) begin
         n_fail++;
         $display("FAIL wrap_tick got %s want hc=1 vc=0 blank=0 csync_n=1 tick=1", fmt(obs()));
      end
   endtask

   task automatic test_random_resets();
      for (int k = 0; k < 3; k++) begin
         int n;
         n = $urandom_range(200, 3000);
         for (int i = 0; i < n; i++) begin
            step();
            n_assert++;
            if (obs() !== expv()) begin
               n_fail++;
               $display("FAIL rand_run got %s want %s", fmt(obs()), fmt(expv()));
            end
         end
         test_async_reset(mh, mv, "rand_reset");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_assert = 0;
      n_fail   = 0;
      mh = 0;
      mv = 0;
      mo = 3'b110;
      rst_n = 1'b0;
      test_reset();
      test_normal_line();
      test_vertical_interval();
      test_broad_wrap();
      test_async_reset(420, VA + 2, "async_broad");
      test_frame_wrap();
      test_random_resets();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
